// File: rtl/hms_pkg.sv
// Shared encodings, field limits and small arithmetic helpers for the
// hour/minute/second time-keeping core.
package hms_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    // Using >= means a corrupted out-of-range value heals itself on the next update.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] limit);
        return (value >= limit) ? 6'd0 : value + 6'd1;
    endfunction

    function automatic pos_t next_pos(input pos_t pos);
        case (pos)
            POS_SEC: return POS_MIN;
            POS_MIN: return POS_HOUR;
            default: return POS_SEC;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, consecutive-sample debounce
// and a single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic          differ;
    logic          accept;

    assign differ = (sync2_reg != level_reg);
    assign accept = differ && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            // Any sample agreeing with the accepted level restarts the count.
            if (!differ || accept) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
            if (accept) begin
                level_reg <= sync2_reg;
            end
            press_reg <= accept && sync2_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/hms_clock_ctrl.sv
// Time-keeping core: one-second divider, RUN/SET mode FSM, field editing
// and blink mask for the six-digit FND display path.
module hms_clock_ctrl
    import hms_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_mode,
    input  logic       i_btn_pos,
    input  logic       i_btn_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hour,
    output logic       o_mode,
    output logic [1:0] o_set_pos,
    output logic [5:0] o_blink,
    output logic       o_tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(TICK_DIV / 2 - 1);
    localparam logic [TW-1:0] TW_ONE    = TW'(1);

    localparam int BTN_MODE = 0;
    localparam int BTN_POS  = 1;
    localparam int BTN_INC  = 2;

    logic [2:0] btn_raw;
    logic [2:0] btn_press;
    logic       press_mode;
    logic       press_pos;
    logic       press_inc;

    assign btn_raw[BTN_MODE] = i_btn_mode;
    assign btn_raw[BTN_POS]  = i_btn_pos;
    assign btn_raw[BTN_INC]  = i_btn_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_btn_debounce (
                .clk  (clk),
                .rst_n(rst_n),
                .btn  (btn_raw[gi]),
                .press(btn_press[gi])
            );
        end
    endgenerate

    assign press_mode = btn_press[BTN_MODE];
    assign press_pos  = btn_press[BTN_POS];
    assign press_inc  = btn_press[BTN_INC];

    state_t      state_reg, state_next;
    pos_t        pos_reg, pos_next;
    logic [5:0]  sec_reg, sec_next;
    logic [5:0]  min_reg, min_next;
    logic [5:0]  hour_reg, hour_next;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic        phase_reg, phase_next;
    logic [5:0]  blink_reg, blink_next;
    logic        tick_reg;
    logic        tick_evt;
    logic        leave_set;

    assign tick_evt  = (cnt_reg == TICK_LAST);
    assign leave_set = (state_reg == ST_SET) && press_mode;

    // Divider and blink phase; leaving SET restarts both so the first
    // second after editing is a full one.
    always_comb begin
        cnt_next   = cnt_reg + TW_ONE;
        phase_next = phase_reg;
        if (tick_evt) begin
            cnt_next = '0;
        end
        if (tick_evt || (cnt_reg == HALF_LAST)) begin
            phase_next = ~phase_reg;
        end
        if (leave_set) begin
            cnt_next   = '0;
            phase_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        sec_next   = sec_reg;
        min_next   = min_reg;
        hour_next  = hour_reg;
        case (state_reg)
            ST_RUN: begin
                // Time advances on the tick even if this same cycle enters SET.
                if (tick_evt) begin
                    sec_next = wrap_inc(sec_reg, SEC_MAX);
                    if (sec_reg >= SEC_MAX) begin
                        min_next = wrap_inc(min_reg, MIN_MAX);
                        if (min_reg >= MIN_MAX) begin
                            hour_next = wrap_inc(hour_reg, HOUR_MAX);
                        end
                    end
                end
                if (press_mode) begin
                    state_next = ST_SET;
                    pos_next   = POS_SEC;
                end
            end
            ST_SET: begin
                if (press_mode) begin
                    state_next = ST_RUN;
                end else if (press_pos) begin
                    pos_next = next_pos(pos_reg);
                end else if (press_inc) begin
                    case (pos_reg)
                        POS_SEC:  sec_next  = wrap_inc(sec_reg, SEC_MAX);
                        POS_MIN:  min_next  = wrap_inc(min_reg, MIN_MAX);
                        POS_HOUR: hour_next = wrap_inc(hour_reg, HOUR_MAX);
                        default:  sec_next  = sec_reg;
                    endcase
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Mask is built from next-state values so the registered output lines
    // up with the mode, position and phase it describes.
    always_comb begin
        blink_next = '0;
        if (state_next == ST_SET) begin
            case (pos_next)
                POS_SEC:  blink_next[1:0] = {2{phase_next}};
                POS_MIN:  blink_next[3:2] = {2{phase_next}};
                POS_HOUR: blink_next[5:4] = {2{phase_next}};
                default:  blink_next      = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            pos_reg   <= POS_SEC;
            sec_reg   <= '0;
            min_reg   <= '0;
            hour_reg  <= '0;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            blink_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            sec_reg   <= sec_next;
            min_reg   <= min_next;
            hour_reg  <= hour_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            blink_reg <= blink_next;
            tick_reg  <= tick_evt;
        end
    end

    assign o_sec     = sec_reg;
    assign o_min     = min_reg;
    assign o_hour    = hour_reg;
    assign o_mode    = (state_reg == ST_SET);
    assign o_set_pos = pos_reg;
    assign o_blink   = blink_reg;
    assign o_tick    = tick_reg;

endmodule

// File: doc/hms_clock_ctrl.md
Name: hms_clock_ctrl

Overview:
- Time-keeping core for the six-digit FND display path. It produces hour/minute/second values that feed the two-digit separators, segment decoders and the six-digit multiplexed display driver.
- One-second timing comes from an internal divider on the system clock; three push-buttons select RUN/SET mode, the field being edited, and increment that field.
- Also outputs a per-digit blink mask so the display path can flash the field under edit.

Parameters:
- TICK_DIV, 50000000, clk cycles per second (50 MHz board clock).
- DEB_CYCLES, 500000, consecutive stable samples required to accept a button level (10 ms).

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset; synchronous, active-low
- i_btn_mode  input  1  raw button, active-high, asynchronous to clk
- i_btn_pos  input  1  raw button, selects the field to edit
- i_btn_inc  input  1  raw button, increments the selected field
- o_sec  output  6  seconds, 0..59
- o_min  output  6  minutes, 0..59
- o_hour  output  6  hours, 0..23 (6 bits so it matches the 0~59 separator input)
- o_mode  output  1  0 = RUN, 1 = SET
- o_set_pos  output  2  field under edit: 0 = sec, 1 = min, 2 = hour; 3 never occurs
- o_blink  output  6  digit blank mask: [1:0] sec, [3:2] min, [5:4] hour; 1 = blank
- o_tick  output  1  one-cycle pulse per second

Behaviour:
- Reset: one clk, one synchronous active-low reset rst_n. All outputs and internal state are registered, and all go to 0 on rst_n = 0 at a clk edge. This includes state (RUN), position, blink phase, tick counter, debounce counters and synchronizers. Reset asserted mid-edit discards the edit.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: the accepted level changes only after DEB_CYCLES consecutive samples that differ from the accepted level; any matching sample clears the counter.
  - A rising edge of the accepted level gives a one-cycle press pulse.
  - No auto-repeat; release has no effect.
  - Press pulse appears DEB_CYCLES+2 to DEB_CYCLES+3 cycles after the raw edge, and the outputs update on the following edge.
- Tick divider:
  - cnt runs 0..TICK_DIV-1 and wraps.
  - o_tick = 1 for exactly the cycle after cnt == TICK_DIV-1.
  - Blink phase toggles when cnt == TICK_DIV/2-1 and when cnt == TICK_DIV-1.
  - Leaving SET clears cnt and phase, so the first second after editing is a full second.
- FSM states RUN and SET:
  - RUN --press_mode--> SET, with o_set_pos = 0.
  - SET --press_mode--> RUN.
  - In SET, press_pos cycles 0 -> 1 -> 2 -> 0.
- RUN update, on each tick:
  - sec+1; at 59 it wraps to 0 and carries into min.
  - min at 59 wraps to 0 and carries into hour.
  - hour at 23 wraps to 0, so 23:59:59 -> 00:00:00 in a single cycle.
  - press_pos and press_inc are ignored in RUN.
- SET update:
  - Ticks do not advance time.
  - press_inc increments only the selected field, with wrap (sec/min 59 -> 0, hour 23 -> 0) and no carry into other fields.
- Simultaneous events:
  - Priority is press_mode > press_pos > press_inc; lower-priority presses in the same cycle are dropped.
  - A tick coinciding with a RUN -> SET press still advances time, because the update uses the current state.
- o_blink:
  - All 0 in RUN.
  - In SET, the selected field's 2 bits equal {phase, phase}; other bits are 0.
- Arithmetic: all comparisons use >= limit, so out-of-range values (impossible by construction) wrap to 0 on the next update.

Decomposition:
- Package hms_pkg holds:
  - state encoding ST_RUN / ST_SET;
  - position encoding POS_SEC / POS_MIN / POS_HOUR;
  - limits SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
- Sub-module btn_debounce (synchronizer, debounce counter, rise pulse; parameter DEB_CYCLES), instantiated three times.
- Tick divider, FSM and counters stay in the top module.

Test Plan (TICK_DIV = 10, DEB_CYCLES = 4):
- Reset, then run 600 cycles -> o_tick pulses every 10 cycles; o_sec steps 0..59 then 0; o_min = 1 at the 60th tick.
- Use SET to load 23:59:59, leave SET, wait 10 cycles -> 00:00:00 in one step, with o_tick high in that cycle.
- Press mode -> o_mode = 1, o_set_pos = 0, o_blink[1:0] toggles 11/00 every 5 cycles. Press pos twice -> o_set_pos = 2, blink on [5:4]. Press inc 24 times -> o_hour returns to its start value, o_min/o_sec unchanged.
- 3-cycle glitch on i_btn_inc in SET -> no change. Hold i_btn_inc for 50 cycles -> exactly one increment; release -> no further change.
- In RUN, assert i_btn_mode and i_btn_inc on the same cycle -> SET entered, selected field not incremented, o_set_pos = 0.
- During SET with edits pending, drive rst_n low for one cycle -> next edge all outputs are 0 and o_mode = 0; 10 cycles later o_sec = 1.
